// File: rtl/irq_request_unit.sv
// Interrupt requester: edge-detects peripheral sources into IF (0xFF0F), drives
// CPU_IRQ_TRIG and clears IF on CPU_IRQ_ACK. Optional input synchronizer: IRQ_SYNC_EN.
module irq_request_unit #(
  parameter int          N_SRC   = 5,
  parameter logic [15:0] IF_ADDR = 16'hFF0F
) (
  input  logic             CLK,
  input  logic             nRES,
  input  logic [N_SRC-1:0] IRQ_SRC,
  input  logic [15:0]      A,
  input  logic             RD,
  input  logic             WR,
  input  logic [7:0]       D_IN,
  output logic [7:0]       D_OUT,
  output logic             D_OE,
  output logic [7:0]       CPU_IRQ_TRIG,
  input  logic [7:0]       CPU_IRQ_ACK
);

  typedef enum logic [0:0] {ACK_IDLE = 1'b0, ACK_HOLD = 1'b1} ack_state_t;

  ack_state_t       ack_state, ack_state_nx;
  logic [N_SRC-1:0] ack_mask, ack_mask_nx;
  logic [N_SRC-1:0] ack_vec, clr;
  logic [N_SRC-1:0] if_reg, if_nx;
  logic [N_SRC-1:0] src_now, src_q, rise;
  logic [1:0]       sup_cnt;
  logic             armed, hit, wr_hit;
  logic             unused_bits;

  // Edges to skip after reset release so a source held high through reset never requests
`ifdef IRQ_SYNC_EN
  localparam logic [1:0] SUP_EDGES = 2'd3;
  logic [N_SRC-1:0] sync1, sync2;

  // Two-flop synchronizer followed by the edge-detect history register
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      sync1 <= '0;
      sync2 <= '0;
      src_q <= '0;
    end else begin
      sync1 <= IRQ_SRC;
      sync2 <= sync1;
      src_q <= sync2;
    end
  end
  assign src_now = sync2;
`else
  localparam logic [1:0] SUP_EDGES = 2'd1;

  // Edge-detect history register on the raw (CLK-synchronous) sources
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      src_q <= '0;
    end else begin
      src_q <= IRQ_SRC;
    end
  end
  assign src_now = IRQ_SRC;
`endif

  // Post-reset suppression counter
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      sup_cnt <= 2'd0;
    end else if (sup_cnt != SUP_EDGES) begin
      sup_cnt <= sup_cnt + 2'd1;
    end else begin
      sup_cnt <= sup_cnt;
    end
  end

  assign armed   = (sup_cnt == SUP_EDGES);
  assign rise    = armed ? (src_now & ~src_q) : '0;
  assign ack_vec = CPU_IRQ_ACK[N_SRC-1:0];
  assign hit     = (A == IF_ADDR);
  assign wr_hit  = WR & hit;

  // Ack FSM: each acked bit clears once per ack assertion
  always_comb begin
    ack_state_nx = ack_state;
    ack_mask_nx  = ack_mask;
    clr          = '0;
    case (ack_state)
      ACK_IDLE: begin
        if (ack_vec != '0) begin
          clr          = ack_vec;
          ack_mask_nx  = ack_vec;
          ack_state_nx = ACK_HOLD;
        end else begin
          ack_mask_nx  = '0;
        end
      end
      ACK_HOLD: begin
        if (ack_vec != '0) begin
          clr         = ack_vec & ~ack_mask;
          ack_mask_nx = ack_mask | ack_vec;
        end else begin
          ack_mask_nx  = '0;
          ack_state_nx = ACK_IDLE;
        end
      end
      default: begin
        ack_mask_nx  = '0;
        ack_state_nx = ACK_IDLE;
      end
    endcase
  end

  // Ack FSM state and mask registers
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      ack_state <= ACK_IDLE;
      ack_mask  <= '0;
    end else begin
      ack_state <= ack_state_nx;
      ack_mask  <= ack_mask_nx;
    end
  end

  // IF next state: write, then clear, then hardware rise wins
  always_comb begin
    if_nx = if_reg;
    if (wr_hit) begin
      if_nx = D_IN[N_SRC-1:0];
    end else begin
      if_nx = if_reg;
    end
    if_nx = (if_nx & ~clr) | rise;
  end

  // IF register
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      if_reg <= '0;
    end else begin
      if_reg <= if_nx;
    end
  end

  assign CPU_IRQ_TRIG = {{(8-N_SRC){1'b0}}, if_reg};
  assign D_OUT        = {{(8-N_SRC){1'b1}}, if_reg};
  assign D_OE         = RD & hit;
  assign unused_bits  = ^{D_IN[7:N_SRC], CPU_IRQ_ACK[7:N_SRC]};

endmodule

// File: tb/tb_irq_request_unit.sv
// Directed scoreboard bench for irq_request_unit: expected values are queued
// when stimulus is applied and popped when the DUT output is sampled.
module tb_irq_request_unit;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        nRES = 1'b0;
  logic [4:0]  IRQ_SRC = 5'h00;
  logic [15:0] A = 16'h0000;
  logic        RD = 1'b0;
  logic        WR = 1'b0;
  logic [7:0]  D_IN = 8'h00;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  CPU_IRQ_TRIG;
  logic [7:0]  CPU_IRQ_ACK = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  irq_request_unit dut (
    .CLK(CLK), .nRES(nRES), .IRQ_SRC(IRQ_SRC), .A(A), .RD(RD), .WR(WR),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .CPU_IRQ_TRIG(CPU_IRQ_TRIG),
    .CPU_IRQ_ACK(CPU_IRQ_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input logic [7:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input logic [7:0] obs);
    logic [7:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic check_trig(input string tag, input logic [7:0] v);
    expect_val(tag, v);
    compare(CPU_IRQ_TRIG);
  endtask

  task automatic check_read(input string tag, input logic [7:0] v);
    expect_val(tag, v);
    A = 16'hFF0F;
    RD = 1'b1;
    #1;
    compare(D_OUT);
    expect_val({tag, "_oe"}, 8'h01);
    compare({7'd0, D_OE});
    RD = 1'b0;
    #1;
    expect_val({tag, "_oe_off"}, 8'h00);
    compare({7'd0, D_OE});
  endtask

  task automatic sw_write(input logic [7:0] d);
    A = 16'hFF0F;
    D_IN = d;
    WR = 1'b1;
    tick(1);
    WR = 1'b0;
  endtask

  initial begin
    // 1. Reset with all sources high
    IRQ_SRC = 5'h1F;
    tick(3);
    check_trig("reset_trig", 8'h00);
    check_read("reset_read", 8'hE0);
    nRES = 1'b1;
    tick(6);
    check_trig("held_src_no_req", 8'h00);
    check_read("held_src_read", 8'hE0);
    A = 16'hFF10;
    RD = 1'b1;
    #1;
    expect_val("oe_other_addr", 8'h00);
    compare({7'd0, D_OE});
    RD = 1'b0;
    IRQ_SRC = 5'h00;
    tick(LAT + 2);
    check_trig("src_fall_no_req", 8'h00);

    // 2. Timer rise, then held high sets IF only once
    IRQ_SRC = 5'h04;
    if (LAT > 1) tick(LAT - 1);
    check_trig("timer_before_edge", 8'h00);
    tick(1);
    check_trig("timer_trig", 8'h04);
    check_read("timer_read", 8'hE4);
    CPU_IRQ_ACK = 8'h04;
    tick(1);
    check_trig("timer_acked", 8'h00);
    CPU_IRQ_ACK = 8'h00;
    tick(10);
    check_trig("timer_held_once", 8'h00);
    IRQ_SRC = 5'h00;
    tick(LAT + 1);

    // 3. Ack hold and re-raise during hold
    sw_write(8'h05);
    check_trig("ack_setup", 8'h05);
    CPU_IRQ_ACK = 8'h01;
    tick(1);
    check_trig("ack_first_edge", 8'h04);
    IRQ_SRC = 5'h01;
    tick(LAT);
    check_trig("reraise_in_hold", 8'h05);
    tick(1);
    check_trig("hold_no_reclear", 8'h05);
    CPU_IRQ_ACK = 8'h00;
    tick(1);
    check_trig("ack_released", 8'h05);
    CPU_IRQ_ACK = 8'h01;
    tick(1);
    check_trig("second_ack_clears", 8'h04);
    CPU_IRQ_ACK = 8'h00;
    IRQ_SRC = 5'h00;
    tick(LAT + 1);

    // 4. Software writes, upper D_IN bits ignored, multi-bit ack
    sw_write(8'hFF);
    check_trig("write_ff_trig", 8'h1F);
    check_read("write_ff_read", 8'hFF);
    CPU_IRQ_ACK = 8'hE9;
    tick(1);
    check_trig("multi_ack", 8'h16);
    CPU_IRQ_ACK = 8'h00;
    tick(1);
    sw_write(8'hE3);
    check_trig("write_upper_ignored", 8'h03);
    check_read("write_e3_read", 8'hE3);
    sw_write(8'h00);
    check_trig("write_00_trig", 8'h00);

    // 5. Collision: write 0 + ack + rise on the same edge
    sw_write(8'h1F);
    A = 16'hFF0F;
    D_IN = 8'h00;
    WR = 1'b1;
    CPU_IRQ_ACK = 8'h02;
    IRQ_SRC = 5'h02;
    if (LAT > 1) begin
      tick(1);
      WR = 1'b0;
      CPU_IRQ_ACK = 8'h00;
      tick(LAT - 1);
    end else begin
      tick(1);
      WR = 1'b0;
      CPU_IRQ_ACK = 8'h00;
    end
    check_trig("collision_rise_wins", 8'h02);
    tick(1);
    check_trig("collision_settled", 8'h02);
    IRQ_SRC = 5'h00;
    tick(LAT + 1);

    // 6. Async reset in ACK_HOLD
    sw_write(8'h1F);
    CPU_IRQ_ACK = 8'h01;
    tick(1);
    check_trig("hold_before_reset", 8'h1E);
    nRES = 1'b0;
    #2;
    check_trig("async_reset_trig", 8'h00);
    check_read("async_reset_read", 8'hE0);
    CPU_IRQ_ACK = 8'h00;
    tick(1);
    nRES = 1'b1;
    tick(LAT + 2);
    sw_write(8'h1F);
    CPU_IRQ_ACK = 8'h01;
    tick(1);
    check_trig("idle_after_reset", 8'h1E);
    CPU_IRQ_ACK = 8'h00;
    tick(2);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
